dpram: RTL

- Data-memory responder at the far end of the core's `dpram_*` interface. It answers the MEM stage's word accesses: combinational read, synchronous full-word write.
- Byte and halfword merging is done by the initiator, so this block only ever sees whole words.
- A second port (B) serves the loader/debug master over a valid/ready request with a one-cycle registered response.
- Port A (core) always has priority over port B.

---
 rtl/dpram_if.sv | 40 ++++
 rtl/dpram.sv | 101 ++++++++++
 2 files changed

// File: rtl/dpram_if.sv
// Bus bundle for the data-memory responder: core port A (MEM stage),
// loader/debug port B (valid/ready request, registered response) and
// the busy indication.
interface dpram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // port A (core)
  logic                  dpram_ce_i;
  logic                  dpram_we_i;
  logic [ADDR_WIDTH-1:0] dpram_addr_i;
  logic [DATA_WIDTH-1:0] dpram_data_i;
  logic [DATA_WIDTH-1:0] dpram_data_o;
  // port B (loader/debug)
  logic                  b_valid_i;
  logic                  b_ready_o;
  logic                  b_we_i;
  logic [ADDR_WIDTH-1:0] b_addr_i;
  logic [DATA_WIDTH-1:0] b_wdata_i;
  logic                  b_rvalid_o;
  logic [DATA_WIDTH-1:0] b_rdata_o;
  // status
  logic                  busy_o;

  modport slave (
    input  dpram_ce_i, dpram_we_i, dpram_addr_i, dpram_data_i,
    output dpram_data_o,
    input  b_valid_i, b_we_i, b_addr_i, b_wdata_i,
    output b_ready_o, b_rvalid_o, b_rdata_o,
    output busy_o
  );

  modport master (
    output dpram_ce_i, dpram_we_i, dpram_addr_i, dpram_data_i,
    input  dpram_data_o,
    output b_valid_i, b_we_i, b_addr_i, b_wdata_i,
    input  b_ready_o, b_rvalid_o, b_rdata_o,
    input  busy_o
  );
endinterface

// File: rtl/dpram.sv
// Data-memory responder. Port A: combinational read, synchronous
// full-word write, always has priority. Port B: valid/ready request with
// a one-cycle registered response (IDLE -> RESP -> IDLE).
// Optional macro DPRAM_CLEAR_EN: after reset release the array is swept
// to zero, one word per cycle, before port B is served.
module dpram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input logic     clk_i,
  input logic     rst_i,
  dpram_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_CLEAR} state_t;

`ifdef DPRAM_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0]      idx_a, idx_b;
  logic                  wr_a, conflict, ready, accept, clearing;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Word index: byte offset dropped, upper bits alias modulo depth.
  assign idx_a = bus.dpram_addr_i[IDX_W+1:2];
  assign idx_b = bus.b_addr_i[IDX_W+1:2];

  // Only the index bits of the addresses matter.
  logic unused_addr;
  assign unused_addr = ^{bus.dpram_addr_i, bus.b_addr_i};

`ifdef DPRAM_CLEAR_EN
  logic [IDX_W-1:0] clr_cnt;
  assign clearing = (state == S_CLEAR);
`else
  assign clearing = 1'b0;
`endif

  // Port A writes are dropped while the array is being cleared.
  assign wr_a     = bus.dpram_ce_i & bus.dpram_we_i & ~clearing;
  // Same-index port A write blocks port B for this cycle; A wins.
  assign conflict = bus.dpram_ce_i & bus.dpram_we_i & (idx_a == idx_b);
  // rst_i gates ready so it reads 0 while reset is held.
  assign ready    = rst_i & (state == S_IDLE) & ~conflict;
  assign accept   = bus.b_valid_i & ready;

  assign bus.dpram_data_o = (bus.dpram_ce_i & ~clearing) ? mem[idx_a] : '0;
  assign bus.b_ready_o    = ready;
  assign bus.b_rvalid_o   = (state == S_RESP);
  assign bus.b_rdata_o    = rdata_q;
  assign bus.busy_o       = rst_i & clearing;

  // Next-state: one response cycle per accepted request, sweep ends at last word.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
`ifdef DPRAM_CLEAR_EN
      S_CLEAR: if (clr_cnt == IDX_W'(DEPTH_WORDS - 1)) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset drops any response in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= RST_STATE;
    else        state <= state_nxt;
  end

`ifdef DPRAM_CLEAR_EN
  // Sweep counter; restarts from 0 on every reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)        clr_cnt <= '0;
    else if (clearing) clr_cnt <= clr_cnt + 1'b1;
  end
`endif

  // Port B response data: pre-edge word for reads, 0 for write acks.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      rdata_q <= '0;
    else if (accept) rdata_q <= bus.b_we_i ? '0 : mem[idx_b];
  end

  // Array writes; A and B never hit the same index in one cycle.
  always_ff @(posedge clk_i) begin
    if (wr_a)               mem[idx_a] <= bus.dpram_data_i;
    if (accept & bus.b_we_i) mem[idx_b] <= bus.b_wdata_i;
`ifdef DPRAM_CLEAR_EN
    if (clearing & rst_i)   mem[clr_cnt] <= '0;
`endif
  end
endmodule
